// File: rtl/brisc_pkg.sv
// Shared brisc core types and widths, including the memory arbiter's state and source encodings.
package brisc_pkg;

   localparam int ADDRESS_WIDTH    = 32;
   localparam int CACHE_LINE_WIDTH = 128;

   typedef enum logic {ARB_IDLE, ARB_WAIT_FILL} arb_state_e;
   typedef enum logic {SRC_IC, SRC_DC} arb_src_e;

endpackage

// File: rtl/arb_rr_picker.sv
// Two-way request picker for mem_arbiter; grant[0] = icache, grant[1] = dcache.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the dcache always wins ties.
import brisc_pkg::*;

module arb_rr_picker (
   input  logic [1:0] req,
   input  arb_src_e   last,
   output logic [1:0] grant
);

`ifndef MEM_ARB_RR_EN
   // Fixed priority keeps last_grant tracked upstream but ignores it here.
   logic unused_last;
   assign unused_last = (last == SRC_DC);
`endif

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
         2'b11: begin
`ifdef MEM_ARB_RR_EN
            grant = (last == SRC_IC) ? 2'b10 : 2'b01;
`else
            grant = 2'b10;
`endif
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the cache-line memory port between icache and dcache with one outstanding fill.
// Tie-break selected by MEM_ARB_RR_EN (see arb_rr_picker).
import brisc_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W = ADDRESS_WIDTH,
   parameter int LINE_W = CACHE_LINE_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_ack,
   output logic              ic_fill,
   input  logic              dc_req,
   input  logic              dc_store,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_data,
   output logic              dc_ack,
   output logic              dc_fill,
   output logic [ADDR_W-1:0] fill_addr_o,
   output logic [LINE_W-1:0] fill_data_o,
   output logic              mem_req,
   output logic              mem_store,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_data,
   input  logic              mem_fill,
   input  logic [ADDR_W-1:0] mem_fill_addr,
   input  logic [LINE_W-1:0] mem_fill_data
);

   arb_state_e        state;
   arb_src_e          owner;
   arb_src_e          last_grant;
   logic [ADDR_W-1:0] pend_addr;
   logic [1:0]        grant;
   logic              can_grant;
   logic              fill_hit;

   arb_rr_picker u_picker (
      .req   ({dc_req, ic_req}),
      .last  (last_grant),
      .grant (grant)
   );

   assign can_grant = !reset && (state == ARB_IDLE);
   assign ic_ack    = can_grant && grant[0];
   assign dc_ack    = can_grant && grant[1];

   // Only a fill matching the pending line closes the transaction; the payload is broadcast regardless.
   assign fill_hit    = !reset && (state == ARB_WAIT_FILL) && mem_fill && (mem_fill_addr == pend_addr);
   assign ic_fill     = fill_hit && (owner == SRC_IC);
   assign dc_fill     = fill_hit && (owner == SRC_DC);
   assign fill_addr_o = mem_fill_addr;
   assign fill_data_o = mem_fill_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB_IDLE;
         owner      <= SRC_IC;
         last_grant <= SRC_IC;
         pend_addr  <= '0;
         mem_req    <= 1'b0;
         mem_store  <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
      end else begin
         mem_req <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (dc_ack) begin
                  mem_req    <= 1'b1;
                  mem_store  <= dc_store;
                  mem_addr   <= dc_addr;
                  mem_data   <= dc_data;
                  last_grant <= SRC_DC;
                  // Evictions need no fill, so the port is free again next cycle.
                  if (!dc_store) begin
                     owner     <= SRC_DC;
                     pend_addr <= dc_addr;
                     state     <= ARB_WAIT_FILL;
                  end
               end else if (ic_ack) begin
                  mem_req    <= 1'b1;
                  mem_store  <= 1'b0;
                  mem_addr   <= ic_addr;
                  mem_data   <= '0;
                  last_grant <= SRC_IC;
                  owner      <= SRC_IC;
                  pend_addr  <= ic_addr;
                  state      <= ARB_WAIT_FILL;
               end
            end
            ARB_WAIT_FILL: begin
               if (fill_hit) begin
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations are hand-computed per step.
// Honours MEM_ARB_RR_EN for the tie-break expectations.
`timescale 1ns/1ps
import brisc_pkg::*;

module tb_mem_arbiter;

   localparam int AW = ADDRESS_WIDTH;
   localparam int LW = CACHE_LINE_WIDTH;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic          ic_ack;
   logic          ic_fill;
   logic          dc_req;
   logic          dc_store;
   logic [AW-1:0] dc_addr;
   logic [LW-1:0] dc_data;
   logic          dc_ack;
   logic          dc_fill;
   logic [AW-1:0] fill_addr_o;
   logic [LW-1:0] fill_data_o;
   logic          mem_req;
   logic          mem_store;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_data;
   logic          mem_fill;
   logic [AW-1:0] mem_fill_addr;
   logic [LW-1:0] mem_fill_data;

   int check_count = 0;
   int pass_count  = 0;

   logic [LW-1:0] evict_data;
   logic [LW-1:0] fill_pattern;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .ic_req        (ic_req),
      .ic_addr       (ic_addr),
      .ic_ack        (ic_ack),
      .ic_fill       (ic_fill),
      .dc_req        (dc_req),
      .dc_store      (dc_store),
      .dc_addr       (dc_addr),
      .dc_data       (dc_data),
      .dc_ack        (dc_ack),
      .dc_fill       (dc_fill),
      .fill_addr_o   (fill_addr_o),
      .fill_data_o   (fill_data_o),
      .mem_req       (mem_req),
      .mem_store     (mem_store),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .mem_fill      (mem_fill),
      .mem_fill_addr (mem_fill_addr),
      .mem_fill_data (mem_fill_data)
   );

   task automatic checkOutput(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Inputs change 1ns after a rising edge; combinational outputs are checked 1ns later.
   task automatic applyStimulus(input logic icr, input logic [AW-1:0] ica,
                                input logic dcr, input logic dcs, input logic [AW-1:0] dca,
                                input logic [LW-1:0] dcd,
                                input logic mf, input logic [AW-1:0] mfa, input logic [LW-1:0] mfd);
      ic_req        = icr;
      ic_addr       = ica;
      dc_req        = dcr;
      dc_store      = dcs;
      dc_addr       = dca;
      dc_data       = dcd;
      mem_fill      = mf;
      mem_fill_addr = mfa;
      mem_fill_data = mfd;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   initial begin
      evict_data   = {16{8'hA5}};
      fill_pattern = {4{32'hDEAD_BEEF}};
      reset = 1'b1;
      idleInputs();
      step();

      // Reset gating of ack and reset values of the registered request
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("ack_in_reset", ic_ack, 1'b0);
      step();
      checkOutput("rst_mem_req", mem_req, 1'b0);
      checkOutput("rst_mem_store", mem_store, 1'b0);
      checkOutput("rst_mem_addr", mem_addr, '0);
      checkOutput("rst_mem_data", mem_data, '0);

      // Icache read: ack in cycle 0, pulse in cycle 1
      reset = 1'b0;
      #1;
      checkOutput("ic_ack_c0", ic_ack, 1'b1);
      checkOutput("dc_ack_c0", dc_ack, 1'b0);
      step();
      idleInputs();
      checkOutput("ic_mem_req", mem_req, 1'b1);
      checkOutput("ic_mem_store", mem_store, 1'b0);
      checkOutput("ic_mem_addr", mem_addr, 32'h40);
      checkOutput("ic_mem_data", mem_data, '0);
      step();
      checkOutput("mem_req_one_cycle", mem_req, 1'b0);

      // Dcache blocked while icache fill is outstanding; stray address is dropped
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 1'b0, '0, '0);
      checkOutput("blocked_dc_ack_a", dc_ack, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 1'b1, 32'h44, fill_pattern);
      checkOutput("mismatch_ic_fill", ic_fill, 1'b0);
      checkOutput("mismatch_dc_fill", dc_fill, 1'b0);
      checkOutput("fill_addr_pass", fill_addr_o, 32'h44);
      checkOutput("blocked_dc_ack_b", dc_ack, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 1'b1, 32'h40, fill_pattern);
      checkOutput("match_ic_fill", ic_fill, 1'b1);
      checkOutput("match_dc_fill", dc_fill, 1'b0);
      checkOutput("fill_data_pass", fill_data_o, fill_pattern);
      checkOutput("no_ack_on_fill_cycle", dc_ack, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 1'b0, '0, '0);
      checkOutput("dc_ack_after_fill", dc_ack, 1'b1);
      step();
      idleInputs();
      checkOutput("dc_rd_mem_req", mem_req, 1'b1);
      checkOutput("dc_rd_mem_addr", mem_addr, 32'h100);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h100, fill_pattern);
      checkOutput("dc_fill_strobe", dc_fill, 1'b1);
      checkOutput("dc_fill_no_ic", ic_fill, 1'b0);
      step();

      // Fill arriving while idle is dropped
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h100, fill_pattern);
      checkOutput("stray_ic_fill", ic_fill, 1'b0);
      checkOutput("stray_dc_fill", dc_fill, 1'b0);

      // Evict then read back-to-back
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h80, evict_data, 1'b0, '0, '0);
      checkOutput("evict_ack", dc_ack, 1'b1);
      step();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h80, '0, 1'b0, '0, '0);
      checkOutput("evict_mem_req", mem_req, 1'b1);
      checkOutput("evict_mem_store", mem_store, 1'b1);
      checkOutput("evict_mem_data", mem_data, evict_data);
      checkOutput("readback_ack", dc_ack, 1'b1);
      step();
      idleInputs();
      checkOutput("readback_mem_req", mem_req, 1'b1);
      checkOutput("readback_mem_store", mem_store, 1'b0);
      checkOutput("readback_mem_addr", mem_addr, 32'h80);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h80, fill_pattern);
      checkOutput("readback_fill", dc_fill, 1'b1);
      step();

      // Ties: dcache wins first after reset in both modes
      reset = 1'b1;
      idleInputs();
      step();
      reset = 1'b0;
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, '0, 1'b0, '0, '0);
      checkOutput("tie1_dc_ack", dc_ack, 1'b1);
      checkOutput("tie1_ic_ack", ic_ack, 1'b0);
      step();
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("tie1_mem_addr", mem_addr, 32'h300);
      checkOutput("tie1_ic_waits", ic_ack, 1'b0);
      step();
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, '0, '0, 1'b1, 32'h300, fill_pattern);
      checkOutput("tie1_dc_fill", dc_fill, 1'b1);
      step();
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h304, '0, 1'b0, '0, '0);
`ifdef MEM_ARB_RR_EN
      checkOutput("tie2_ic_ack", ic_ack, 1'b1);
      checkOutput("tie2_dc_ack", dc_ack, 1'b0);
      step();
      idleInputs();
      checkOutput("tie2_mem_addr", mem_addr, 32'h200);
`else
      checkOutput("tie2_ic_ack", ic_ack, 1'b0);
      checkOutput("tie2_dc_ack", dc_ack, 1'b1);
      step();
      idleInputs();
      checkOutput("tie2_mem_addr", mem_addr, 32'h304);
`endif
      step();

      // Reset mid-fill abandons the pending line; strobes are held low during reset
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, mem_addr, fill_pattern);
      checkOutput("rst_cycle_ic_fill", ic_fill, 1'b0);
      checkOutput("rst_cycle_dc_fill", dc_fill, 1'b0);
      step();
      reset = 1'b0;
`ifdef MEM_ARB_RR_EN
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 1'b1, 32'h200, fill_pattern);
`else
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 1'b1, 32'h304, fill_pattern);
`endif
      checkOutput("late_ic_fill", ic_fill, 1'b0);
      checkOutput("late_dc_fill", dc_fill, 1'b0);
      checkOutput("post_rst_ic_ack", ic_ack, 1'b1);
      step();
      idleInputs();
      checkOutput("post_rst_mem_req", mem_req, 1'b1);
      checkOutput("post_rst_mem_addr", mem_addr, 32'h500);
      step();

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single cache-line memory port between the instruction cache and the data cache of the brisc core. Accepts one request at a time from either cache, drives the memory request interface with registered outputs, tracks the one outstanding line fill, and routes the returning fill only to the cache that issued it. Sits between the core's two caches and `memory`, replacing the direct core-to-memory hookup.

## Interface
Parameters:
- `ADDR_W`: default `ADDRESS_WIDTH`. Line address width.
- `LINE_W`: default `CACHE_LINE_WIDTH`. Cache line width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ic_req`  in  1  icache read request; held with `ic_addr` until acked.
- `ic_addr`  in  ADDR_W  icache line address.
- `ic_ack`  out  1  combinational; the request is accepted at this edge.
- `ic_fill`  out  1  fill strobe for icache.
- `dc_req`  in  1  dcache request; held with `dc_store`, `dc_addr` and `dc_data` until acked.
- `dc_store`  in  1  1 = evict/write-back, 0 = line read.
- `dc_addr`  in  ADDR_W  dcache line address.
- `dc_data`  in  LINE_W  eviction data.
- `dc_ack`  out  1  combinational accept.
- `dc_fill`  out  1  fill strobe for dcache.
- `fill_addr_o`, `fill_data_o`  out  ADDR_W / LINE_W  fill payload, broadcast to both caches.
- `mem_req`, `mem_store`  out  1  registered request to memory; `mem_req` is a one-cycle pulse.
- `mem_addr`, `mem_data`  out  ADDR_W / LINE_W  registered request payload.
- `mem_fill`  in  1  fill strobe from memory.
- `mem_fill_addr`, `mem_fill_data`  in  ADDR_W / LINE_W  fill payload from memory.

## Operation
- States: `IDLE`, `WAIT_FILL`. Registers: `owner` (IC/DC), `pend_addr`, `last_grant`.
- In `IDLE`, with at least one request pending, exactly one ack is asserted combinationally. At that edge the arbiter:
  - registers `mem_req=1`, `mem_store`, `mem_addr` and `mem_data` from the winner; `mem_data` is 0 for icache;
  - sets `last_grant` to the winner.
- Read grant: captures `owner` and `pend_addr`, then moves to `WAIT_FILL`.
- Store grant: stays in `IDLE`. A new grant is allowed in the very next cycle, so back-to-back `mem_req` pulses are legal.
- Tie-break when both request: see Configuration. A lone requester always wins.
- In `WAIT_FILL`: no acks, and `mem_req=0`.
  - `mem_fill` with `mem_fill_addr==pend_addr` asserts `ic_fill` or `dc_fill` (per `owner`) combinationally in the same cycle, then returns to `IDLE`.
  - A fill whose address does not match is dropped, and the state is held.
- `mem_fill` in `IDLE` is dropped; neither fill strobe asserts.
- `fill_addr_o` and `fill_data_o` are pass-throughs of `mem_fill_addr` and `mem_fill_data`. Only the strobes are gated.

## Timing
- Reset values: `mem_req`, `mem_store` = 0; `mem_addr`, `mem_data` = 0; state `IDLE`; `owner` = IC; `last_grant` = IC; `pend_addr` = 0.
- Reset also forces acks and fill strobes to 0 during the reset cycle.
- Ack at edge N puts `mem_req` high in cycle N+1, for exactly one cycle.
- The requester must drop or replace its request at edge N.
- Minimum read turnaround: fill seen in cycle F means the next ack is possible in cycle F+1. There is no same-cycle fill-then-grant.
- Reset while in `WAIT_FILL` abandons the outstanding fill. A late `mem_fill` after reset is ignored, because the arbiter is in `IDLE`.
- A request arriving in the same cycle as a fill is not acked until the following cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break. The requester that is not `last_grant` wins; after reset the dcache wins the first tie.
- `MEM_ARB_RR_EN` not defined: fixed priority, and the dcache always wins ties. `last_grant` is still maintained but does not affect the grant.

## Structure
- Add to `brisc_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_WAIT_FILL} arb_state_e`;
  - `typedef enum logic {SRC_IC, SRC_DC} arb_src_e`.
  - `ADDRESS_WIDTH` and `CACHE_LINE_WIDTH` already live there.
- One sub-module, `arb_rr_picker`, is natural. It is a combinational two-way picker taking `req[1:0]` and `last`, and returning a one-hot `grant`. The `MEM_ARB_RR_EN` switch lives inside it.

## Test plan
- Icache read only: `ic_req`, `ic_addr=0x40` → `ic_ack` in cycle 0; cycle 1 has `mem_req=1`, `mem_store=0`, `mem_addr=0x40`; a fill with addr `0x40` 5 cycles later → `ic_fill=1` for that one cycle, `dc_fill=0`.
- Dcache evict then read back-to-back: store to `0x80` with `dc_data=0xA5..` → `mem_store=1` pulse; the next cycle's read to `0x80` is acked immediately, giving consecutive `mem_req` pulses.
- Simultaneous requests with `MEM_ARB_RR_EN` defined: after reset, DC wins; after DC's fill, IC wins the next tie. Without the macro, DC wins both.
- Blocking: `dc_req` raised while in `WAIT_FILL` for IC → `dc_ack=0` until one cycle after the matching fill.
- Mismatched or stray fill: fill addr `0x44` while pending `0x40` → no strobe, still waiting; a fill in `IDLE` → no strobe.
- Reset mid-fill: `reset` in `WAIT_FILL`, then `mem_fill` → no strobe, state `IDLE`, and a new `ic_req` is acked.
